// File: rtl/v_beat_engine.sv
// v_beat_engine: multi-beat vector execution engine.
// Runs one vector instruction (element-wise ALU, unit-stride load or store)
// LANES elements per cycle over NBEATS beats against a narrow VRAM port and
// returns ALU/load results through a valid/ready write-back port.
// Every output is a register loaded from the next-state decode, so memory
// strobes for beat k appear in the same cycle the engine sits on beat k.
module v_beat_engine #(
    parameter int VLEN   = 512,
    parameter int ELEN   = 32,
    parameter int LANES  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [4:0]             req_vd,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [VLEN-1:0]        req_v1,
    input  logic [VLEN-1:0]        req_v2,
    output logic                   mem_r_ena,
    output logic                   mem_w_ena,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [LANES*ELEN-1:0]  mem_w_data,
    output logic [LANES*ELEN-1:0]  mem_w_mask,
    input  logic [LANES*ELEN-1:0]  mem_r_data,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [4:0]             wb_addr,
    output logic [VLEN-1:0]        wb_data,
    output logic                   done,
    output logic                   illegal
);

    localparam int W      = LANES * ELEN;
    localparam int NBEATS = VLEN / W;
    localparam int KW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [KW-1:0]     K_LAST     = KW'(NBEATS - 1);
    localparam logic [KW-1:0]     K_ZERO     = {KW{1'b0}};
    localparam logic [KW-1:0]     K_ONE      = KW'(1'b1);
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(W / 8);

    localparam logic [2:0] OP_VADD = 3'd0;
    localparam logic [2:0] OP_VSUB = 3'd1;
    localparam logic [2:0] OP_VMUL = 3'd2;
    localparam logic [2:0] OP_VLE  = 3'd3;
    localparam logic [2:0] OP_VSE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALU    = 3'd1,
        S_LOAD   = 3'd2,
        S_LDRAIN = 3'd3,
        S_STORE  = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [KW-1:0]       k_r, k_s;
    logic [2:0]          op_r;
    logic [4:0]          vd_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [VLEN-1:0]     v1_r, v2_r, result_r;
    logic                accept_s, done_s, illegal_s, store_last_s;
    logic [ADDR_W-1:0]   base_s, nxt_addr_s;
    logic [VLEN-1:0]     src_v1_s;
    logic [W-1:0]        alu_beat_s;
    logic [W-1:0]        v1_beats_s [NBEATS];
    logic [W-1:0]        v2_beats_s [NBEATS];
    logic [W-1:0]        st_beats_s [NBEATS];

    // Next-state and beat-counter decode.
    always_comb begin
        state_s   = state_r;
        k_s       = k_r;
        accept_s  = 1'b0;
        done_s    = 1'b0;
        illegal_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                k_s = K_ZERO;
                if (req_valid) begin
                    accept_s = 1'b1;
                    case (req_op)
                        OP_VADD, OP_VSUB, OP_VMUL: state_s = S_ALU;
                        OP_VLE:                    state_s = S_LOAD;
                        OP_VSE:                    state_s = S_STORE;
                        default: begin
                            state_s   = S_IDLE;
                            illegal_s = 1'b1;
                            done_s    = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ALU: begin
                if (k_r == K_LAST) begin
                    state_s = S_WB;
                    k_s     = K_ZERO;
                end else begin
                    k_s = k_r + K_ONE;
                end
            end
            S_LOAD: begin
                if (k_r == K_LAST) begin
                    state_s = S_LDRAIN;
                    k_s     = K_ZERO;
                end else begin
                    k_s = k_r + K_ONE;
                end
            end
            S_LDRAIN: begin
                state_s = S_WB;
                k_s     = K_ZERO;
            end
            S_STORE: begin
                if (k_r == K_LAST) begin
                    state_s = S_IDLE;
                    k_s     = K_ZERO;
                end else begin
                    k_s = k_r + K_ONE;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    state_s = S_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = S_WB;
                end
            end
            default: begin
                state_s = S_IDLE;
                k_s     = K_ZERO;
            end
        endcase
    end

    // Beat views of the operands; store data comes straight from the request on the accept cycle.
    always_comb begin
        src_v1_s = (state_r == S_IDLE) ? req_v1 : v1_r;
        for (int b = 0; b < NBEATS; b++) begin
            v1_beats_s[b] = v1_r[b*W +: W];
            v2_beats_s[b] = v2_r[b*W +: W];
            st_beats_s[b] = src_v1_s[b*W +: W];
        end
    end

    // Next memory address and the last-store-beat marker.
    always_comb begin
        base_s       = (state_r == S_IDLE) ? req_addr : addr_r;
        nxt_addr_s   = base_s + (ADDR_W'(k_s) * BEAT_BYTES);
        store_last_s = (state_s == S_STORE) && (k_s == K_LAST);
    end

    // Per-lane ALU for the current beat; arithmetic stays inside each ELEN lane.
    always_comb begin
        alu_beat_s = {W{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            case (op_r)
                OP_VADD: alu_beat_s[l*ELEN +: ELEN] = v1_beats_s[k_r][l*ELEN +: ELEN] + v2_beats_s[k_r][l*ELEN +: ELEN];
                OP_VSUB: alu_beat_s[l*ELEN +: ELEN] = v1_beats_s[k_r][l*ELEN +: ELEN] - v2_beats_s[k_r][l*ELEN +: ELEN];
                OP_VMUL: alu_beat_s[l*ELEN +: ELEN] = v1_beats_s[k_r][l*ELEN +: ELEN] * v2_beats_s[k_r][l*ELEN +: ELEN];
                default: alu_beat_s[l*ELEN +: ELEN] = {ELEN{1'b0}};
            endcase
        end
    end

    // State register and beat counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
            k_r     <= K_ZERO;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
        end
    end

    // Instruction latch, loaded only on the accept cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_r   <= 3'd0;
            vd_r   <= 5'd0;
            addr_r <= {ADDR_W{1'b0}};
            v1_r   <= {VLEN{1'b0}};
            v2_r   <= {VLEN{1'b0}};
        end else if (accept_s) begin
            op_r   <= req_op;
            vd_r   <= req_vd;
            addr_r <= req_addr;
            v1_r   <= req_v1;
            v2_r   <= req_v2;
        end
    end

    // Result vector: ALU beats land at slot k, load data lags its request by one beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_r <= {VLEN{1'b0}};
        end else begin
            for (int b = 0; b < NBEATS; b++) begin
                if ((state_r == S_ALU) && (k_r == KW'(b))) begin
                    result_r[b*W +: W] <= alu_beat_s;
                end else if ((state_r == S_LOAD) && (k_r != K_ZERO) && (k_r == KW'(b + 1))) begin
                    result_r[b*W +: W] <= mem_r_data;
                end else if ((state_r == S_LDRAIN) && (b == NBEATS - 1)) begin
                    result_r[b*W +: W] <= mem_r_data;
                end
            end
        end
    end

    // Registered handshake, memory and status outputs driven from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_ready  <= 1'b1;
            mem_r_ena  <= 1'b0;
            mem_w_ena  <= 1'b0;
            mem_addr   <= {ADDR_W{1'b0}};
            mem_w_data <= {W{1'b0}};
            mem_w_mask <= {W{1'b0}};
            wb_valid   <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            req_ready  <= (state_s == S_IDLE);
            mem_r_ena  <= (state_s == S_LOAD);
            mem_w_ena  <= (state_s == S_STORE);
            mem_addr   <= ((state_s == S_LOAD) || (state_s == S_STORE)) ? nxt_addr_s : {ADDR_W{1'b0}};
            mem_w_data <= (state_s == S_STORE) ? st_beats_s[k_s] : {W{1'b0}};
            mem_w_mask <= (state_s == S_STORE) ? {W{1'b1}} : {W{1'b0}};
            wb_valid   <= (state_s == S_WB);
            done       <= done_s | store_last_s;
            illegal    <= illegal_s;
        end
    end

    assign wb_addr = vd_r;
    assign wb_data = result_r;

endmodule

// File: doc/v_beat_engine.md
# v_beat_engine

Parametrised multi-beat vector execution engine, the successor to the single-cycle vector core datapath. It accepts one vector instruction per request handshake: element-wise ALU op, unit-stride load or unit-stride store. Each instruction is processed `LANES` elements per cycle over `VLEN/(LANES*ELEN)` beats against a narrow, synchronous-read VRAM port. ALU and load results are returned to the vector regfile through a valid/ready write-back port.

## Interface
Parameters:
- `VLEN`, 512, vector register width in bits.
- `ELEN`, 32, element width in bits.
- `LANES`, 4, elements per beat. Beat width is `W = LANES*ELEN`. `VLEN % W == 0` is required. `NBEATS = VLEN/W`.
- `ADDR_W`, 32, VRAM byte-address width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `req_valid` input 1: instruction request valid.
- `req_ready` output 1: engine can accept a request.
- `req_op` input 3: 0 VADD, 1 VSUB, 2 VMUL, 3 VLE, 4 VSE, 5–7 illegal.
- `req_vd` input 5: destination vector register.
- `req_addr` input ADDR_W: base byte address for VLE and VSE.
- `req_v1` input VLEN: operand 1 (ALU) or store data (VSE).
- `req_v2` input VLEN: operand 2 (ALU).
- `mem_r_ena` output 1: VRAM read strobe.
- `mem_w_ena` output 1: VRAM write strobe.
- `mem_addr` output ADDR_W: shared read/write byte address.
- `mem_w_data` output W: store beat data.
- `mem_w_mask` output W: per-bit write mask.
- `mem_r_data` input W: read data, valid the cycle after `mem_r_ena`.
- `wb_valid` output 1: result valid.
- `wb_ready` input 1: regfile accepts result.
- `wb_addr` output 5: destination register.
- `wb_data` output VLEN: result vector.
- `done` output 1: one-cycle pulse when an instruction retires.
- `illegal` output 1: one-cycle pulse when an illegal op is accepted.

## Operation
- States: IDLE, ALU, LOAD, LDRAIN, STORE, WB.
- `req_ready = (state==IDLE)`. Accept on `req_valid && req_ready`. At accept, latch op, vd, addr, v1, v2 and set beat counter `k=0`.
- **ALU.** Each cycle computes beat k: result bits `[k*W +: W]` from operand bits `[k*W +: W]`, each element independently.
  - VADD is `v1+v2`, VSUB is `v1-v2`, VMUL is the low ELEN bits of `v1*v2`.
  - All arithmetic is modulo 2^ELEN; no carry crosses element boundaries.
  - After beat NBEATS-1, go to WB.
- **LOAD.** Each cycle issue `mem_r_ena=1` with `mem_addr = addr + k*(W/8)`. Data returned in the following cycle is written to result bits `[(k-1)*W +: W]`.
  - After issuing beat NBEATS-1, go to LDRAIN. LDRAIN captures the last beat and goes to WB.
- **STORE.** Each cycle drive `mem_w_ena=1`, `mem_addr = addr + k*(W/8)`, `mem_w_data = v1[k*W +: W]`, `mem_w_mask` all ones.
  - After beat NBEATS-1, pulse `done` on that same cycle and return to IDLE. No write-back.
- Address arithmetic wraps modulo 2^ADDR_W.
- **WB.** `wb_valid=1`, `wb_addr=vd`, `wb_data=result`. On `wb_valid && wb_ready`: pulse `done`, go to IDLE.
- **Illegal op (5–7).** Accepted; `illegal` and `done` pulse the cycle after accept. Engine stays in IDLE. No memory access, no write-back.
- `mem_r_ena` and `mem_w_ena` are never both high. Outside LOAD/STORE both are 0, and `mem_addr`, `mem_w_data`, `mem_w_mask` are 0.

## Timing
- **Reset.** `rst==0` at a rising edge forces IDLE, clears the counter, and forces all outputs to 0 at the next edge. `req_ready` then reads 1 because the engine is in IDLE.
- **Reset mid-instruction.** The instruction is discarded: no further memory strobes, no write-back, no `done`.
- **Latency.** With accept at edge E0:
  - ALU: `wb_valid` rises after edge E0+NBEATS.
  - VLE: first `mem_r_ena` in the cycle after E0; `wb_valid` rises after E0+NBEATS+1.
  - VSE: strobes in cycles E0+1 … E0+NBEATS; `req_ready` is high again after edge E0+NBEATS.
- **Back-pressure.** While `wb_ready=0`, `wb_valid`, `wb_addr` and `wb_data` are held stable and `req_ready=0`.
- **Throughput.** After a write-back handshake, `req_ready` is high the following cycle (one-cycle bubble). A new request is never accepted in the handshake cycle.
- Request inputs are ignored except in the accept cycle.

## Test plan
Defaults for all scenarios: W=128, NBEATS=4, byte stride 16.
- **Reset.** Hold `rst=0` for 2 cycles with random inputs → all outputs 0. After `rst=1`, `req_ready=1`.
- **VADD wrap.** `v1` element i = i, `v2` = all 0xFFFFFFFF, vd=7 → `wb_valid` 4 cycles after accept, element i = i-1 (element 0 = 0xFFFFFFFF), `wb_addr=7`, `done` on handshake.
- **VLE at 0x100.** → `mem_r_ena` with addresses 0x100, 0x110, 0x120, 0x130 on consecutive cycles. Returned beats B0..B3 appear at `wb_data[k*128 +: 128]`. `wb_valid` 5 cycles after accept.
- **VSE wrap.** Addr 0xFFFFFFF0 → addresses 0xFFFFFFF0, 0x0, 0x10, 0x20; mask all ones; data = `v1` beats in order. No `wb_valid`. `done` on the 4th beat.
- **Back-pressure and illegal.** VMUL 0x10000×0x10000 → elements 0. Hold `wb_ready=0` for 3 cycles → outputs stable, `req_ready=0`. Next request accepted one cycle after the handshake. Then op=6 → `illegal` and `done` pulse, no memory activity.
- **Reset mid-LOAD.** Drive `rst=0` during beat 2 → next cycle all strobes 0, IDLE, no `wb_valid` and no `done` afterwards.
